// File: rtl/press_classifier_pkg.sv
// Shared definitions for the button gesture blocks.
// The state encoding lives here so later gesture classifiers can reuse it.
package press_classifier_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd2,
        GAP       = 3'd3,
        PRESS2    = 3'd4
    } press_state_t;

endpackage

// File: rtl/press_classifier.sv
// Classifies a debounced, clk-synchronous button level into short, long and
// double presses, emitting one single-cycle registered pulse per gesture.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int unsigned LONG_COUNT = 32'd50_000_000,
    parameter int unsigned GAP_COUNT  = 32'd25_000_000,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic short_press,
    output logic long_press,
    output logic double_press,
    output logic busy
);

    localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] GAP_LAST  = CNT_WIDTH'(GAP_COUNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    press_state_t          state;
    logic [CNT_WIDTH-1:0]  cnt;

    // busy is registered alongside the state, so it reflects the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            busy         <= 1'b0;
        end else begin
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn) begin
                        state <= PRESS1;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end
                end
                PRESS1: begin
                    if (btn && cnt == LONG_LAST) begin
                        long_press <= 1'b1;
                        state      <= LONG_HELD;
                    end else if (btn) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        state <= GAP;
                        cnt   <= CNT_ONE;
                    end
                end
                LONG_HELD: begin
                    if (!btn) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                GAP: begin
                    if (!btn && cnt == GAP_LAST) begin
                        short_press <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end else if (!btn) begin
                        cnt <= cnt + CNT_ONE;
                    end else begin
                        state <= PRESS2;
                        cnt   <= '0;
                    end
                end
                PRESS2: begin
                    // A second press never turns into a long press, however long it is held.
                    if (!btn) begin
                        double_press <= 1'b1;
                        state        <= IDLE;
                        busy         <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_classifier.sv
// Scoreboard bench for press_classifier: each gesture pushes its expected pulse
// (kind and clock edge) and a negedge monitor pops and compares every pulse seen.
module tb_press_classifier;

    localparam int LONG_N = 8;
    localparam int GAP_N  = 5;

    localparam int K_SHORT  = 1;
    localparam int K_LONG   = 2;
    localparam int K_DOUBLE = 4;

    typedef struct {
        int kind;
        int edge_idx;
    } exp_t;

    logic clk;
    logic rst_n;
    logic btn;
    logic short_press;
    logic long_press;
    logic double_press;
    logic busy;

    int   checks   = 0;
    int   failures = 0;
    int   edge_count = 0;
    exp_t exp_q[$];

    press_classifier #(
        .LONG_COUNT(LONG_N),
        .GAP_COUNT (GAP_N),
        .CNT_WIDTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .short_press (short_press),
        .long_press  (long_press),
        .double_press(double_press),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_count <= edge_count + 1;

    task automatic check_output(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (edge %0d)", tag, observed, expected, edge_count);
        end
    endtask

    // Drives n consecutive samples of level b; returns positioned at a negedge.
    task automatic apply_stimulus(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            btn = b;
            @(negedge clk);
        end
    endtask

    task automatic expect_pulse(input int kind, input int edge_idx);
        exp_t e;
        e.kind     = kind;
        e.edge_idx = edge_idx;
        exp_q.push_back(e);
    endtask

    // Any pulse seen must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [2:0] pulses;
        exp_t       e;
        pulses = {double_press, long_press, short_press};
        if (pulses != 3'b000) begin
            check_output("onehot", $countones(pulses), 1);
            if (exp_q.size() == 0) begin
                check_output("spurious_pulse", int'(pulses), 0);
            end else begin
                e = exp_q.pop_front();
                check_output("pulse_kind", int'(pulses), e.kind);
                check_output("pulse_edge", edge_count, e.edge_idx);
            end
        end
    end

    initial begin
        int e0;
        rst_n = 1'b0;
        btn   = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_pulses", int'({double_press, long_press, short_press}), 0);
        check_output("reset_busy", int'(busy), 0);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 2);
        check_output("idle_busy", int'(busy), 0);

        $display("[TB] short press");
        e0 = edge_count;
        expect_pulse(K_SHORT, e0 + 3 + GAP_N);
        apply_stimulus(1'b1, 3);
        check_output("short_busy_held", int'(busy), 1);
        apply_stimulus(1'b0, 10);
        check_output("short_busy_after", int'(busy), 0);
        check_output("short_pending", exp_q.size(), 0);

        $display("[TB] long press");
        e0 = edge_count;
        expect_pulse(K_LONG, e0 + LONG_N);
        apply_stimulus(1'b1, 30);
        check_output("long_busy_held", int'(busy), 1);
        apply_stimulus(1'b0, 1);
        check_output("long_busy_release", int'(busy), 0);
        apply_stimulus(1'b0, 8);
        check_output("long_pending", exp_q.size(), 0);

        $display("[TB] double press");
        e0 = edge_count;
        expect_pulse(K_DOUBLE, e0 + 3 + 2 + 3 + 1);
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 2);
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 10);
        check_output("double_busy_after", int'(busy), 0);
        check_output("double_pending", exp_q.size(), 0);

        $display("[TB] boundary hold and gap");
        e0 = edge_count;
        expect_pulse(K_DOUBLE, e0 + (LONG_N - 1) + (GAP_N - 1) + 20 + 1);
        apply_stimulus(1'b1, LONG_N - 1);
        apply_stimulus(1'b0, GAP_N - 1);
        apply_stimulus(1'b1, 20);
        check_output("boundary_busy_held", int'(busy), 1);
        apply_stimulus(1'b0, 10);
        check_output("boundary_pending", exp_q.size(), 0);

        $display("[TB] reset mid gap");
        apply_stimulus(1'b1, 3);
        apply_stimulus(1'b0, 2);
        rst_n = 1'b0;
        #1;
        check_output("async_reset_pulses", int'({double_press, long_press, short_press}), 0);
        check_output("async_reset_busy", int'(busy), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b0, 10);
        check_output("reset_gap_busy", int'(busy), 0);
        check_output("reset_gap_pending", exp_q.size(), 0);

        $display("[TB] press held across reset release");
        rst_n = 1'b0;
        btn   = 1'b1;
        @(negedge clk);
        @(negedge clk);
        e0 = edge_count;
        expect_pulse(K_LONG, e0 + LONG_N);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 10);
        apply_stimulus(1'b0, 5);
        check_output("held_reset_busy", int'(busy), 0);

        check_output("final_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
